// File: rtl/fsm_counter_driver.sv
// Initiator-side controller for the start/stop counter interface.
// Issues a one-cycle start, watches the 3-bit count, fires a one-cycle stop
// so that the counter takes it while showing the latched target, then checks
// twice that the counter froze one step past the target. The outcome is
// reported as a sticky done or a sticky err with an err_code.
//
// Handshake: req/target are sampled on any rising clk edge while busy is low
// (IDLE or FIN). busy rises with start and falls on the same edge that done
// or err rises. A req seen while busy is dropped, not queued.
//
// Timing for a counter that starts from idle (req high in cycle t):
//   start at t+1, stop at t+3+target, done at t+6+target, cycles = target+2.
// The stop pulse cycle is spent in CHECK1 with stop high. CHECK1 only
// compares the count in the following cycle, once the counter has taken stop.
module fsm_counter_driver #(
  parameter int TIMEOUT = 20,
  parameter int STOP_LO = 5,
  parameter int STOP_HI = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [2:0] target,
  input  logic [2:0] counter,
  output logic       start,
  output logic       stop,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] cycles,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_CHECK1 = 3'd2,
    S_CHECK2 = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  localparam logic [2:0] LO   = 3'(STOP_LO);
  localparam logic [2:0] HI   = 3'(STOP_HI);
  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [1:0] err_code_q, err_code_d;
  logic [7:0] cycles_q, cycles_d;
  logic [7:0] timer_q, timer_d;
  logic [2:0] target_q, target_d;

  logic       target_ok;
  logic       stop_hit;
  logic       timer_exp;
  logic       frozen_ok;

  // Decodes shared by the next-state and output processes.
  always_comb begin
    target_ok = (target >= LO) && (target <= HI);
    stop_hit  = (counter == (target_q - 3'd1));
    timer_exp = (timer_q == TMAX);
    frozen_ok = (counter == (target_q + 3'd1));
  end

  // State and output registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      cycles_q   <= 8'd0;
      timer_q    <= 8'd0;
      target_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cycles_q   <= cycles_d;
      timer_q    <= timer_d;
      target_q   <= target_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (req) state_d = target_ok ? S_WAIT : S_FIN;
      end
      S_WAIT: begin
        if (stop_hit)       state_d = S_CHECK1;
        else if (timer_exp) state_d = S_FIN;
      end
      S_CHECK1: begin
        if (!stop_q) state_d = frozen_ok ? S_CHECK2 : S_FIN;
      end
      S_CHECK2: state_d = S_FIN;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; stop wins over timeout in WAIT.
  always_comb begin
    start_d    = 1'b0;
    stop_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    cycles_d   = cycles_q;
    timer_d    = timer_q;
    target_d   = target_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (req) begin
          done_d   = 1'b0;
          cycles_d = 8'd0;
          if (target_ok) begin
            target_d   = target;
            err_d      = 1'b0;
            err_code_d = 2'd0;
            timer_d    = 8'd0;
            start_d    = 1'b1;
            busy_d     = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
            busy_d     = 1'b0;
          end
        end
      end
      S_WAIT: begin
        timer_d  = timer_q + 8'd1;
        cycles_d = (cycles_q == 8'hFF) ? 8'hFF : cycles_q + 8'd1;
        if (stop_hit) begin
          stop_d = 1'b1;
        end else if (timer_exp) begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
          busy_d     = 1'b0;
        end
      end
      S_CHECK1: begin
        if (!stop_q && !frozen_ok) begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
          busy_d     = 1'b0;
        end
      end
      S_CHECK2: begin
        busy_d = 1'b0;
        if (frozen_ok) begin
          done_d = 1'b1;
        end else begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign start     = start_q;
  assign stop      = stop_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign cycles    = cycles_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fsm_counter_driver.sv
// Bench for fsm_counter_driver: a behavioural counter FSM on the far side,
// randomized commands, a timing/result model pushing into expected queues,
// and a negedge monitor that pops and compares as pulses and results appear.
module tb_fsm_counter_driver;

  localparam int TIMEOUT = 20;
  localparam int W = 29; // done, err, code[2], chk_cycles, cycles[8], fin_cycle[16]

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [2:0] target;
  logic [2:0] counter;
  logic       start, stop, busy, done, err;
  logic [1:0] err_code;
  logic [7:0] cycles;
  logic [2:0] state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  int           exp_start_q[$];
  int           exp_stop_q[$];

  // counter model controls
  logic hold_mode  = 1'b0;
  logic extra_mode = 1'b0;
  logic arm, running, extra;
  logic last_err = 1'b0;

  fsm_counter_driver #(.TIMEOUT(TIMEOUT), .STOP_LO(5), .STOP_HI(6)) dut (
    .clk(clk), .rst(rst), .req(req), .target(target), .counter(counter),
    .start(start), .stop(stop), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .cycles(cycles), .state_dbg(state_dbg)
  );

  // clock and cycle index
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter FSM: one idle cycle after start, then counts from 0; takes stop
  // with one last increment and freezes. extra_mode adds one rogue increment.
  always @(posedge clk) begin
    if (!rst) begin
      counter <= 3'd0; arm <= 1'b0; running <= 1'b0; extra <= 1'b0;
    end else if (hold_mode) begin
      counter <= 3'd6; arm <= 1'b0; running <= 1'b0; extra <= 1'b0;
    end else begin
      arm <= start;
      if (arm) begin
        counter <= 3'd0; running <= 1'b1;
      end else if (running) begin
        counter <= counter + 3'd1;
        if (stop) begin running <= 1'b0; extra <= extra_mode; end
      end else if (extra) begin
        counter <= counter + 3'd1; extra <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a pulse or a result.
  logic done_p = 1'b0, err_p = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    int t_exp;
    if (start) begin
      if (exp_start_q.size() == 0) check("unexpected_start", cyc, -1);
      else begin
        t_exp = exp_start_q.pop_front();
        check("start_cycle", cyc, t_exp);
        check("busy_at_start", busy, 1);
      end
    end
    if (stop) begin
      if (exp_stop_q.size() == 0) check("unexpected_stop", cyc, -1);
      else begin
        t_exp = exp_stop_q.pop_front();
        check("stop_cycle", cyc, t_exp);
      end
    end
    if ((done && !done_p) || (err && !err_p)) begin
      if (exp_q.size() == 0) check("unexpected_result", cyc, -1);
      else begin
        e = exp_q.pop_front();
        check("result_cycle", cyc, int'(e[15:0]));
        check("done", done, e[28]);
        check("err", err, e[27]);
        check("err_code", err_code, e[26:25]);
        check("busy_at_result", busy, 0);
        if (e[24]) check("cycles", cycles, e[23:16]);
      end
    end
    done_p = done;
    err_p  = err;
  end

  task automatic check_idle(input string tag);
    check({tag, "_start"}, start, 0);
    check({tag, "_stop"}, stop, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_cycles"}, cycles, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete(); exp_start_q.delete(); exp_stop_q.delete();
    last_err = 1'b0;
    check_idle(tag);
  endtask

  // Reference model: timing and outcome from the interface rules.
  // scen 0 nominal, 1 counter moves after freezing, 2 counter stuck at 6.
  task automatic push_expect(input int t, input int tgt, input int scen);
    logic [7:0] cyc_v;
    cyc_v = 8'(tgt + 2);
    if (tgt < 5 || tgt > 6) begin
      exp_q.push_back({1'b0, 1'b1, 2'd1, 1'b0, 8'd0, 16'(t + 1)});
    end else if (scen == 2) begin
      exp_start_q.push_back(t + 1);
      exp_q.push_back({1'b0, 1'b1, 2'd2, 1'b0, 8'd0, 16'(t + 1 + TIMEOUT)});
    end else begin
      exp_start_q.push_back(t + 1);
      exp_stop_q.push_back(t + 3 + tgt);
      if (scen == 0) exp_q.push_back({1'b1, 1'b0, 2'd0, 1'b1, cyc_v, 16'(t + 6 + tgt)});
      else           exp_q.push_back({1'b0, 1'b1, 2'd3, 1'b1, cyc_v, 16'(t + 6 + tgt)});
    end
  endtask

  task automatic run(input int tgt, input int scen);
    int t;
    int n;
    hold_mode  = (scen == 2);
    extra_mode = (scen == 1);
    @(posedge clk); #1;
    t = cyc;
    req = 1'b1;
    target = 3'(tgt);
    push_expect(t, tgt, scen);
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || exp_start_q.size() != 0 || exp_stop_q.size() != 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("run_completed_in_budget", (n < 60) ? 1 : 0, 1);
    if (n >= 60) begin
      exp_q.delete(); exp_start_q.delete(); exp_stop_q.delete();
    end
    last_err = err;
    repeat (2) @(posedge clk);
    hold_mode  = 1'b0;
    extra_mode = 1'b0;
  endtask

  task automatic abort_run();
    int t;
    @(posedge clk); #1;
    t = cyc;
    req = 1'b1;
    target = 3'd5;
    exp_start_q.push_back(t + 1);
    @(posedge clk); #1;
    req = 1'b0;
    while (cyc < t + 5) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("abort_start_seen", exp_start_q.size(), 0);
    exp_q.delete(); exp_start_q.delete(); exp_stop_q.delete();
    last_err = 1'b0;
    check_idle("abort");
    repeat (15) @(posedge clk);
    #1;
    check("abort_done_stays_low", done, 0);
    check("abort_err_stays_low", err, 0);
  endtask

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tgt;
    int scen;
    rst = 1'b0; req = 1'b0; target = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check_idle("por");

    run(5, 0);
    run(6, 0);
    check("done_before_reset", done, 1);
    do_reset("reset_after_done");
    run(3, 0);
    run(6, 2);
    run(6, 1);
    run(5, 1);
    abort_run();

    for (int i = 0; i < 30; i++) begin
      tgt  = $urandom_range(0, 7);
      scen = ($urandom_range(0, 9) == 0) ? 2 : $urandom_range(0, 1);
      if (last_err && (tgt < 5 || tgt > 6)) tgt = 5;
      run(tgt, scen);
    end

    repeat (5) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_counter_driver.md
Name: fsm_counter_driver

Overview:
Initiator-side controller for the start/stop counter FSM interface. It issues the start pulse, watches the counter's 3-bit count, and times a single-cycle stop so that stop is accepted inside the legal window [5,6]. It then confirms the counter froze and reports done or an error code. It sits beside the counter in the demo design as its driver and self-checker, and doubles as a reusable stimulus block for formal and sim harnesses.

Parameters:
TIMEOUT, 20, max cycles in WAIT (counting from the start-pulse cycle) before a timeout error; legal range 10..255.
STOP_LO, 5, lowest legal stop target.
STOP_HI, 6, highest legal stop target.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low (0 = reset)
req  input  1  command request; sampled only when not busy
target  input  3  counter value at which stop must be high; sampled with req
counter  input  3  observed count from the counter FSM
start  output  1  one-cycle start pulse to the counter FSM
stop  output  1  one-cycle stop pulse to the counter FSM
busy  output  1  high from req acceptance until done or err rises
done  output  1  sticky success flag
err  output  1  sticky error flag
err_code  output  2  0 none, 1 bad target, 2 timeout, 3 freeze-check mismatch
cycles  output  8  cycles from the start-pulse cycle to the stop-pulse cycle; saturates at 255

Behaviour:
- Reset: rst=0 at a posedge forces state IDLE; start, stop, busy, done, err = 0; err_code = 0; cycles = 0; internal timer = 0.
- Reset mid-operation: takes effect on the same edge and aborts any run. No further start or stop is driven.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, WAIT, CHECK1, CHECK2, FIN.
- IDLE/FIN, req=1, target in [STOP_LO,STOP_HI]:
  - latch target; clear done, err, err_code and cycles.
  - start=1 and busy=1 next cycle; go to WAIT.
- IDLE/FIN, req=1, target out of range:
  - next cycle err=1, err_code=1, busy=0, no start pulse; go to FIN.
- req while busy (WAIT/CHECK1/CHECK2) is ignored.
- WAIT:
  - start is high only in the first WAIT cycle.
  - timer and cycles increment each cycle; cycles counts 0 in the start-pulse cycle.
  - If counter == target-1, set stop=1 for exactly the next cycle and go to CHECK1. cycles freezes at the value in that stop cycle.
  - Else if timer reaches TIMEOUT-1: next cycle err=1, err_code=2, busy=0; go to FIN; stop is never driven.
  - The stop condition takes priority over timeout in the same cycle.
- Nominal timing for a counter that starts from IDLE:
  - req at cycle t; start high at t+1.
  - counter==k at t+3+k; stop high at t+3+target.
  - cycles = target+2.
- CHECK1: the cycle after the stop pulse; counter must equal target+1 (mod 8). Mismatch gives err_code=3.
- CHECK2: counter must still equal target+1. Pass gives done=1 and busy=0 the next cycle; mismatch gives err=1, err_code=3. Both go to FIN.
- Nominal completion: done high at t+6+target.
- done and err are never high together. Both are sticky until the next accepted req or reset.
- All counter arithmetic is 3-bit with wrap (7+1=0).

Test Plan:
- Reset with outputs forced high, then rst=0 for 1 cycle -> all outputs 0 next cycle; state IDLE.
- Nominal run, target=5, req at t with a real counter FSM attached -> start at t+1, stop at t+8 only, done at t+11, cycles=7, err=0.
- target=6 -> stop at t+9 with counter=6 observed, done at t+12, cycles=8.
- target=3 -> err=1 and err_code=1 at t+1, start never asserted, busy stays 0.
- Counter FSM already in its final state (held at 6), req with target=6 -> start pulses, stop never pulses, err=1 with err_code=2 at cycle t+1+TIMEOUT (t+21), busy falls then.
- Mismatch and abort cases:
  - Force counter to increment once after stop (6 then 7) -> err_code=3 after CHECK2.
  - Separately, assert rst=0 at t+5 of a run -> no stop pulse ever appears; all flags 0.
